seg7_display: RTL and testbench

SEG7_DISPLAY -- requirements
Module: seg7_display

---
 rtl/seg7_display.sv | 192 +++++++++++++++++++
 tb/tb_seg7_display.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_display.sv
// Hex seven-segment driver with shadow/active buffering committed at scan-frame boundaries,
// leading-zero blanking, per-digit blink, and both static and multiplexed outputs.
module seg7_display #(
    parameter int DIGITS    = 8,
    parameter int MUX       = 1,
    parameter int CLK_DIV   = 50000,
    parameter int BLINK_DIV = 256
) (
    input  logic                clk,
    input  logic                reset_in,
    input  logic [4*DIGITS-1:0] value,
    input  logic [DIGITS-1:0]   dp,
    input  logic [DIGITS-1:0]   blink_mask,
    input  logic                load,
    input  logic                blank_lz,
    output logic [7*DIGITS-1:0] seg_static,
    output logic [DIGITS-1:0]   dp_static,
    output logic [7:0]          seg_mux,
    output logic [DIGITS-1:0]   dig_an,
    output logic                pending,
    output logic                frame_done
);
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [PW-1:0]       presc_q, presc_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [BW-1:0]       bcnt_q, bcnt_d;
    logic                phase_q, phase_d;
    logic                pending_q, pending_d;
    logic                frame_done_q, frame_done_d;
    logic                valid_q, valid_d;
    logic [4*DIGITS-1:0] shd_val_q, shd_val_d, act_val_q, act_val_d;
    logic [DIGITS-1:0]   shd_dp_q, shd_dp_d, act_dp_q, act_dp_d;
    logic [DIGITS-1:0]   shd_bm_q, shd_bm_d, act_bm_q, act_bm_d;
    logic [7*DIGITS-1:0] seg_static_q, seg_static_d;
    logic [DIGITS-1:0]   dp_static_q, dp_static_d;
    logic [7:0]          seg_mux_q, seg_mux_d;
    logic [DIGITS-1:0]   dig_an_q, dig_an_d;
    logic                tick, boundary, commit;
    logic [6:0]          seg_dig [DIGITS];
    logic [DIGITS-1:0]   dp_dig;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0:    hex7 = 7'h40;
            4'h1:    hex7 = 7'h79;
            4'h2:    hex7 = 7'h24;
            4'h3:    hex7 = 7'h30;
            4'h4:    hex7 = 7'h19;
            4'h5:    hex7 = 7'h12;
            4'h6:    hex7 = 7'h02;
            4'h7:    hex7 = 7'h78;
            4'h8:    hex7 = 7'h00;
            4'h9:    hex7 = 7'h10;
            4'hA:    hex7 = 7'h08;
            4'hB:    hex7 = 7'h03;
            4'hC:    hex7 = 7'h46;
            4'hD:    hex7 = 7'h21;
            4'hE:    hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    assign tick     = (presc_q == PRESC_LAST);
    assign boundary = tick && (idx_q == IDX_LAST);
    assign commit   = boundary && (load || pending_q);

    always_comb begin
        presc_d      = tick ? '0 : presc_q + 1'b1;
        idx_d        = idx_q;
        bcnt_d       = bcnt_q;
        phase_d      = phase_q;
        shd_val_d    = shd_val_q;
        shd_dp_d     = shd_dp_q;
        shd_bm_d     = shd_bm_q;
        act_val_d    = act_val_q;
        act_dp_d     = act_dp_q;
        act_bm_d     = act_bm_q;
        pending_d    = boundary ? 1'b0 : (pending_q || load);
        valid_d      = valid_q || commit;
        frame_done_d = commit;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            if (bcnt_q == BLINK_LAST) begin
                bcnt_d  = '0;
                phase_d = !phase_q;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
        end
        if (load) begin
            shd_val_d = value;
            shd_dp_d  = dp;
            shd_bm_d  = blink_mask;
        end
        // A load landing on the boundary wins over older shadow contents.
        if (boundary && load) begin
            act_val_d = value;
            act_dp_d  = dp;
            act_bm_d  = blink_mask;
        end else if (boundary && pending_q) begin
            act_val_d = shd_val_q;
            act_dp_d  = shd_dp_q;
            act_bm_d  = shd_bm_q;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] nib;
            logic       blink_off, lz_off;
            assign nib       = act_val_q[4*gi +: 4];
            assign blink_off = phase_q && act_bm_q[gi];
            if (gi == 0) begin : g_lsd
                assign lz_off = 1'b0;
            end else begin : g_upper
                // Leading zero: this digit and every more significant digit are zero.
                assign lz_off = blank_lz && (act_val_q[4*DIGITS-1:4*gi] == '0);
            end
            assign seg_dig[gi] = (!valid_q || blink_off || lz_off) ? 7'h7F : hex7(nib);
            assign dp_dig[gi]  = !valid_q || blink_off || !act_dp_q[gi];
            assign seg_static_d[7*gi +: 7] = seg_dig[gi];
        end
    endgenerate
    assign dp_static_d = dp_dig;

    always_comb begin
        seg_mux_d = 8'hFF;
        dig_an_d  = '1;
        if (MUX != 0 && valid_q) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (idx_q == IW'(i)) begin
                    seg_mux_d   = {dp_dig[i], seg_dig[i]};
                    dig_an_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            presc_q      <= '0;
            idx_q        <= '0;
            bcnt_q       <= '0;
            phase_q      <= 1'b0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            valid_q      <= 1'b0;
            shd_val_q    <= '0;
            shd_dp_q     <= '0;
            shd_bm_q     <= '0;
            act_val_q    <= '0;
            act_dp_q     <= '0;
            act_bm_q     <= '0;
            seg_static_q <= '1;
            dp_static_q  <= '1;
            seg_mux_q    <= 8'hFF;
            dig_an_q     <= '1;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            bcnt_q       <= bcnt_d;
            phase_q      <= phase_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
            valid_q      <= valid_d;
            shd_val_q    <= shd_val_d;
            shd_dp_q     <= shd_dp_d;
            shd_bm_q     <= shd_bm_d;
            act_val_q    <= act_val_d;
            act_dp_q     <= act_dp_d;
            act_bm_q     <= act_bm_d;
            seg_static_q <= seg_static_d;
            dp_static_q  <= dp_static_d;
            seg_mux_q    <= seg_mux_d;
            dig_an_q     <= dig_an_d;
        end
    end

    assign seg_static = seg_static_q;
    assign dp_static  = dp_static_q;
    assign seg_mux    = seg_mux_q;
    assign dig_an     = dig_an_q;
    assign pending    = pending_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_seg7_display.sv
// Bench for seg7_display (4 digits, fast scan): decode vectors, commit/scan/blink/reset
// sequences and random stimulus against a cycle-count-based reference model.
module tb_seg7_display;
    localparam int DIGITS    = 4;
    localparam int CLK_DIV   = 4;
    localparam int BLINK_DIV = 2;
    localparam int FRAME     = CLK_DIV * DIGITS;

    logic        clk = 1'b0;
    logic        reset_in = 1'b1;
    logic [15:0] value = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  blink_mask = '0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [27:0] seg_static;
    logic [3:0]  dp_static;
    logic [7:0]  seg_mux;
    logic [3:0]  dig_an;
    logic        pending;
    logic        frame_done;

    seg7_display #(.DIGITS(DIGITS), .MUX(1), .CLK_DIV(CLK_DIV), .BLINK_DIV(BLINK_DIV)) dut (
        .clk(clk), .reset_in(reset_in), .value(value), .dp(dp), .blink_mask(blink_mask),
        .load(load), .blank_lz(blank_lz), .seg_static(seg_static), .dp_static(dp_static),
        .seg_mux(seg_mux), .dig_an(dig_an), .pending(pending), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: scan position and blink phase follow from elapsed clock edges.
    int          n_edges;
    bit          m_pend, m_valid;
    logic [15:0] sh_val, ac_val;
    logic [3:0]  sh_dp, ac_dp, sh_bm, ac_bm;
    logic [27:0] e_seg;
    logic [3:0]  e_dp, e_an;
    logic [7:0]  e_mux;
    bit          e_pend, e_fd;
    logic [6:0]  hex_tab [16];

    typedef struct {
        logic [15:0] val;
        logic [3:0]  dpv;
        logic        blz;
        logic [27:0] seg;
        logic [3:0]  dpn;
    } vec_t;
    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void digit_model(input int i, input bit blz, input int phase,
                                        output logic [6:0] s, output bit dn);
        bit off, lz;
        logic [15:0] upper;
        upper = ac_val >> (4 * i);
        off = !m_valid || (phase == 1 && ac_bm[i]);
        lz  = blz && (i != 0) && (upper == 16'h0);
        s   = (off || lz) ? 7'h7F : hex_tab[upper[3:0]];
        dn  = off || !ac_dp[i];
    endfunction

    task automatic model_reset();
        n_edges = 0; m_pend = 0; m_valid = 0;
        sh_val = '0; ac_val = '0; sh_dp = '0; ac_dp = '0; sh_bm = '0; ac_bm = '0;
    endtask

    task automatic model_edge(input bit ld, input logic [15:0] v, input logic [3:0] d,
                              input logic [3:0] bm, input bit blz);
        int idx, phase;
        bit bnd;
        logic [6:0] s;
        bit dn;
        idx   = (n_edges / CLK_DIV) % DIGITS;
        phase = (n_edges / (CLK_DIV * BLINK_DIV)) % 2;
        e_mux = 8'hFF;
        e_an  = 4'hF;
        for (int i = 0; i < DIGITS; i++) begin
            digit_model(i, blz, phase, s, dn);
            e_seg[7*i +: 7] = s;
            e_dp[i] = dn;
            if (m_valid && i == idx) begin
                e_mux = {dn, s};
                e_an[i] = 1'b0;
            end
        end
        n_edges++;
        bnd  = (n_edges % FRAME) == 0;
        e_fd = bnd && (ld || m_pend);
        if (bnd) begin
            if (ld) begin
                ac_val = v; ac_dp = d; ac_bm = bm;
            end else if (m_pend) begin
                ac_val = sh_val; ac_dp = sh_dp; ac_bm = sh_bm;
            end
            m_pend = 0;
        end else if (ld) begin
            sh_val = v; sh_dp = d; sh_bm = bm; m_pend = 1;
        end
        if (e_fd) m_valid = 1;
        e_pend = m_pend;
    endtask

    task automatic check_all();
        chk("seg_static", seg_static, e_seg);
        chk("dp_static", dp_static, e_dp);
        chk("seg_mux", seg_mux, e_mux);
        chk("dig_an", dig_an, e_an);
        chk("pending", pending, e_pend);
        chk("frame_done", frame_done, e_fd);
    endtask

    task automatic step(input bit ld, input logic [15:0] v, input logic [3:0] d,
                        input logic [3:0] bm, input bit blz);
        load = ld; value = v; dp = d; blink_mask = bm; blank_lz = blz;
        @(posedge clk);
        model_edge(ld, v, d, bm, blz);
        #1;
        check_all();
        load = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_in = 1'b1;
        load = 1'b0;
        #1;
        chk("rst_seg_static", seg_static, 28'hFFFFFFF);
        chk("rst_dp_static", dp_static, 4'hF);
        chk("rst_seg_mux", seg_mux, 8'hFF);
        chk("rst_dig_an", dig_an, 4'hF);
        chk("rst_pending", pending, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        model_reset();
        @(negedge clk);
        reset_in = 1'b0;
    endtask

    task automatic run_to_commit(input logic [3:0] bm, input bit blz);
        bit seen;
        seen = 0;
        for (int k = 0; k < 3 * FRAME && !seen; k++) begin
            step(1'b0, value, dp, bm, blz);
            if (frame_done === 1'b1) seen = 1;
        end
        chk("commit_seen", seen, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  an_q [$];
        logic [3:0]  last_an;
        int          cnt_off, cnt_d3, fd_cnt;
        bit          ld;
        logic [15:0] v;

        hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        vecs[0] = '{16'h12AF, 4'h0, 1'b0, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'hF};
        vecs[1] = '{16'h0050, 4'h0, 1'b1, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'hF};
        vecs[2] = '{16'h0050, 4'h0, 1'b0, {7'h40, 7'h40, 7'h12, 7'h40}, 4'hF};
        vecs[3] = '{16'h0000, 4'h0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF};
        vecs[4] = '{16'h89BC, 4'h5, 1'b1, {7'h00, 7'h10, 7'h03, 7'h46}, 4'hA};
        vecs[5] = '{16'h0D0E, 4'h0, 1'b1, {7'h7F, 7'h21, 7'h40, 7'h06}, 4'hF};
        vecs[6] = '{16'h3467, 4'hF, 1'b0, {7'h30, 7'h19, 7'h02, 7'h78}, 4'h0};

        do_reset();
        step(1'b0, 16'h0, 4'h0, 4'h0, 1'b0);

        // Load, pending until boundary, commit, then scan order.
        step(1'b1, 16'h12AF, 4'h0, 4'h0, 1'b0);
        chk("pending_after_load", pending, 1'b1);
        run_to_commit(4'h0, 1'b0);
        chk("pending_after_commit", pending, 1'b0);
        step(1'b0, value, dp, 4'h0, 1'b0);
        chk("req34_seg", seg_static, {7'h79, 7'h24, 7'h08, 7'h0E});
        chk("req34_dp", dp_static, 4'hF);
        chk("scan_first_an", dig_an, 4'hE);
        chk("scan_first_mux", seg_mux, 8'h8E);
        $display("commit 12AF: seg_static=%h dig_an=%h", seg_static, dig_an);
        an_q.push_back(dig_an);
        last_an = dig_an;
        for (int k = 0; k < FRAME; k++) begin
            step(1'b0, value, dp, 4'h0, 1'b0);
            if (dig_an !== last_an) begin
                an_q.push_back(dig_an);
                last_an = dig_an;
            end
        end
        chk("scan_len", an_q.size(), 5);
        if (an_q.size() == 5) begin
            chk("scan_an0", an_q[0], 4'hE);
            chk("scan_an1", an_q[1], 4'hD);
            chk("scan_an2", an_q[2], 4'hB);
            chk("scan_an3", an_q[3], 4'h7);
            chk("scan_an4", an_q[4], 4'hE);
        end

        // Decode / blanking vectors.
        for (int t = 0; t < 7; t++) begin
            step(1'b1, vecs[t].val, vecs[t].dpv, 4'h0, vecs[t].blz);
            run_to_commit(4'h0, vecs[t].blz);
            step(1'b0, vecs[t].val, vecs[t].dpv, 4'h0, vecs[t].blz);
            chk("vec_seg", seg_static, vecs[t].seg);
            chk("vec_dp", dp_static, vecs[t].dpn);
            $display("vector %0d: value=%h dp=%h blz=%0d seg_static=%h dp_static=%h",
                     t, vecs[t].val, vecs[t].dpv, vecs[t].blz, seg_static, dp_static);
        end

        // Two loads before a boundary collapse into one commit.
        do_reset();
        step(1'b1, 16'h1111, 4'h0, 4'h0, 1'b0);
        step(1'b1, 16'h2222, 4'h0, 4'h0, 1'b0);
        run_to_commit(4'h0, 1'b0);
        step(1'b0, value, dp, 4'h0, 1'b0);
        chk("double_load_seg", seg_static, {7'h24, 7'h24, 7'h24, 7'h24});
        fd_cnt = 0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            step(1'b0, value, dp, 4'h0, 1'b0);
            if (frame_done === 1'b1) fd_cnt++;
        end
        chk("idle_no_frame_done", fd_cnt, 0);
        $display("double load: committed seg_static=%h", seg_static);

        // Load on the boundary edge commits immediately.
        while ((n_edges % FRAME) != FRAME - 1) step(1'b0, value, dp, 4'h0, 1'b0);
        step(1'b1, 16'h3333, 4'h0, 4'h0, 1'b0);
        chk("bypass_pending", pending, 1'b0);
        chk("bypass_frame_done", frame_done, 1'b1);
        step(1'b0, value, dp, 4'h0, 1'b0);
        chk("bypass_seg", seg_static, {7'h30, 7'h30, 7'h30, 7'h30});
        $display("bypass load: seg_static=%h", seg_static);

        // Blink on digit 0 only.
        do_reset();
        step(1'b1, 16'h8888, 4'h0, 4'h1, 1'b0);
        run_to_commit(4'h1, 1'b0);
        cnt_off = 0;
        cnt_d3  = 0;
        for (int k = 0; k < 2 * CLK_DIV * BLINK_DIV * 2; k++) begin
            step(1'b0, value, dp, 4'h1, 1'b0);
            if (seg_static[6:0] === 7'h7F) cnt_off++;
            if (seg_static[27:21] === 7'h00) cnt_d3++;
        end
        chk("blink_off_count", cnt_off, 16);
        chk("blink_steady_digit3", cnt_d3, 32);
        $display("blink: digit0 off %0d of 32 cycles", cnt_off);

        // Reset mid-frame discards pending data.
        step(1'b1, 16'h5A5A, 4'hF, 4'h0, 1'b0);
        step(1'b0, value, dp, 4'h0, 1'b0);
        chk("pre_reset_pending", pending, 1'b1);
        do_reset();
        fd_cnt = 0;
        for (int k = 0; k < 3 * FRAME; k++) begin
            step(1'b0, value, dp, 4'h0, 1'b0);
            if (frame_done === 1'b1) fd_cnt++;
        end
        chk("post_reset_no_frame_done", fd_cnt, 0);
        chk("post_reset_seg", seg_static, 28'hFFFFFFF);
        $display("reset mid-frame: pending=%0d frame_done pulses=%0d", pending, fd_cnt);

        // Random stimulus against the model.
        for (int k = 0; k < 800; k++) begin
            ld = ($urandom_range(0, 7) == 0);
            v = value;
            if (ld) begin
                v = 16'($urandom);
                if ($urandom_range(0, 2) == 0) v = v & (16'hFFFF >> (4 * $urandom_range(1, 4)));
                $display("random load %0d: value=%h", k, v);
            end
            if ($urandom_range(0, 15) == 0) blank_lz = !blank_lz;
            step(ld, v, ld ? 4'($urandom) : dp, ld ? 4'($urandom) : blink_mask, blank_lz);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
